// File: rtl/pll_readback.sv
// -----------------------------------------------------------------------------
// pll_readback
//
// Read-side companion to the PLL control mapper. It brings the asynchronous
// PLL lock output into the clk domain, filters it, and tracks lock acquisition
// time, lock timeouts and lock-loss events. One 32-bit status word is returned
// per read request over a valid/ready handshake.
//
// Parameters:
//   LOCK_FILT     consecutive synchronized-high cycles before lock is accepted (1..15)
//   LOCK_TIMEOUT  ACQ cycles allowed before the timeout flag is set (1..65535)
//
// Ports:
//   clk, rst           block clock, synchronous active-high reset
//   pllen              applied PLL enable (from the control mapper)
//   ratio              applied feedback ratio
//   zdiv0_ratio        applied zdiv0 ratio
//   zdiv1_ratio        applied zdiv1 ratio
//   pll_lock           raw PLL lock, asynchronous to clk
//   rd_req, rd_addr    read request and address
//   rd_ready           consumer accepts rd_data
//   rd_valid           rd_data / rd_err valid
//   rd_data, rd_err    read data, unmapped-address flag
//   pll_locked         high while the FSM is in LOCKED
//   irq                lost_sticky | timeout_flag (only with PLL_READBACK_IRQ_EN)
//
// Optional feature macro: PLL_READBACK_IRQ_EN adds the registered irq output.
//
// Read map:
//   0: {28'b0, lost_sticky, timeout_flag, pll_locked, pllen}  (clears lost_sticky)
//   1: {2'b0, zdiv1_ratio, zdiv0_ratio, ratio}
//   2: {16'b0, lock_time}
//   3: {24'b0, loss_cnt}                                       (clears loss_cnt)
//   4-7: 0 with rd_err=1
// -----------------------------------------------------------------------------
module pll_readback #(
  parameter int unsigned LOCK_FILT    = 4,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pllen,
  input  logic [9:0]  ratio,
  input  logic [9:0]  zdiv0_ratio,
  input  logic [9:0]  zdiv1_ratio,
  input  logic        pll_lock,
  input  logic        rd_req,
  input  logic [2:0]  rd_addr,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic        pll_locked
`ifdef PLL_READBACK_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ACQ,
    ST_LOCKED,
    ST_TIMEOUT
  } state_e;

  localparam logic [3:0] FILT_MAX = 4'(LOCK_FILT);

  // ---------------------------------------------------------------------------
  // Lock synchronizer and filter
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [3:0] filt_cnt_q, filt_cnt_d;
  logic       lock_ok_q;
  logic       lock_ok_d;

  // NOTE: always_comb assigns every output first so no path leaves a value
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    filt_cnt_d = '0;
    if (sync_q[1]) begin
      filt_cnt_d = (filt_cnt_q == FILT_MAX) ? filt_cnt_q : filt_cnt_q + 4'd1;
    end
  end

  // lock_ok is registered from the next count so it changes on the same edge
  // the counter reaches (or leaves) LOCK_FILT.
  assign lock_ok_d = (filt_cnt_d == FILT_MAX);

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // in the block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      filt_cnt_q <= '0;
      lock_ok_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], pll_lock};
      filt_cnt_q <= filt_cnt_d;
      lock_ok_q  <= lock_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read request acceptance and clear-on-read strobes
  // ---------------------------------------------------------------------------
  logic rd_valid_q;
  logic rd_accept;
  logic clr_sticky;
  logic clr_cnt;
  logic loss_event;

  state_e      state_q;
  logic [15:0] lock_time_q;
  logic        timeout_flag_q;
  logic        pll_locked_q;
  logic        lost_sticky_q;
  logic [7:0]  loss_cnt_q;

  assign rd_accept  = rd_req && (!rd_valid_q || rd_ready);
  assign clr_sticky = rd_accept && (rd_addr == 3'd0);
  assign clr_cnt    = rd_accept && (rd_addr == 3'd3);

  // A drop of lock_ok while LOCKED is a loss; pllen low takes priority and is
  // never counted as a loss.
  assign loss_event = pllen && (state_q == ST_LOCKED) && !lock_ok_q;

  // ---------------------------------------------------------------------------
  // Lock FSM with its status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_OFF;
      lock_time_q    <= '0;
      timeout_flag_q <= 1'b0;
      pll_locked_q   <= 1'b0;
      lost_sticky_q  <= 1'b0;
      loss_cnt_q     <= '0;
    end else begin
      if (!pllen) begin
        state_q        <= ST_OFF;
        timeout_flag_q <= 1'b0;
        pll_locked_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            state_q     <= ST_ACQ;
            lock_time_q <= '0;
          end
          ST_ACQ: begin
            if (lock_ok_q) begin
              state_q      <= ST_LOCKED;
              pll_locked_q <= 1'b1;
            end else begin
              if (lock_time_q != 16'hFFFF) lock_time_q <= lock_time_q + 16'd1;
              if (lock_time_q == LOCK_TIMEOUT) begin
                state_q        <= ST_TIMEOUT;
                timeout_flag_q <= 1'b1;
              end
            end
          end
          ST_TIMEOUT: begin
            if (lock_ok_q) begin
              state_q      <= ST_LOCKED;
              pll_locked_q <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!lock_ok_q) begin
              state_q      <= ST_ACQ;
              pll_locked_q <= 1'b0;
              lock_time_q  <= '0;
            end
          end
          default: state_q <= ST_OFF;
        endcase
      end

      // A loss event in the same cycle as a clearing read wins over the clear.
      if (loss_event) begin
        lost_sticky_q <= 1'b1;
        if (clr_cnt)                    loss_cnt_q <= 8'd1;
        else if (loss_cnt_q != 8'hFF)   loss_cnt_q <= loss_cnt_q + 8'd1;
      end else begin
        if (clr_sticky) lost_sticky_q <= 1'b0;
        if (clr_cnt)    loss_cnt_q    <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path (returns pre-clear values)
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    unique case (rd_addr)
      3'd0:    rd_data_d = {28'b0, lost_sticky_q, timeout_flag_q, pll_locked_q, pllen};
      3'd1:    rd_data_d = {2'b0, zdiv1_ratio, zdiv0_ratio, ratio};
      3'd2:    rd_data_d = {16'b0, lock_time_q};
      3'd3:    rd_data_d = {24'b0, loss_cnt_q};
      default: rd_err_d  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else if (rd_accept) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end else if (rd_ready) begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;
  assign pll_locked = pll_locked_q;

`ifdef PLL_READBACK_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= lost_sticky_q | timeout_flag_q;
  end

  assign irq = irq_q;
`endif

endmodule
